// File: rtl/div_share_sched.sv
// Round-robin arbiter sharing one iterative divider among N_REQ requesters.
// Handles divide-by-zero locally and aborts hung divisions with a watchdog.
module div_share_sched #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DW      = 32,
   parameter int unsigned TMO_CYC = 64
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_REQ-1:0]    req_valid_i,
   output logic [N_REQ-1:0]    req_ready_o,
   input  logic [N_REQ*DW-1:0] req_a_i,
   input  logic [N_REQ*DW-1:0] req_b_i,
   output logic                div_start_o,
   output logic [DW-1:0]       div_a_o,
   output logic [DW-1:0]       div_b_o,
   input  logic                div_ready_i,
   input  logic                div_end_i,
   input  logic [DW-1:0]       div_quotient_i,
   input  logic [DW-1:0]       div_remainder_i,
   output logic [N_REQ-1:0]    rsp_valid_o,
   input  logic [N_REQ-1:0]    rsp_ready_i,
   output logic [DW-1:0]       rsp_quotient_o,
   output logic [DW-1:0]       rsp_remainder_o,
   output logic                rsp_div0_o,
   output logic                rsp_tmo_o,
   output logic                busy_o
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = $clog2(TMO_CYC) + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   id_q, id_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [DW-1:0]   quo_q, quo_d;
   logic [DW-1:0]   rem_q, rem_d;
   logic            div0_q, div0_d;
   logic            tmo_q, tmo_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            gnt_found;
   logic [IW-1:0]   gnt;
   logic [DW-1:0]   gnt_a, gnt_b;
   logic            div_start;

   // Requester index 'off' positions above 'base', wrapping modulo N_REQ.
   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned off);
      int unsigned sum;
      sum = (32'(base) + off) % N_REQ;
      return IW'(sum);
   endfunction

   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         if (!gnt_found && req_valid_i[rr_idx(ptr_q, off)]) begin
            gnt_found = 1'b1;
            gnt       = rr_idx(ptr_q, off);
         end
      end
   end

   always_comb begin
      gnt_a = '0;
      gnt_b = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (gnt == IW'(k)) begin
            gnt_a = req_a_i[k*DW +: DW];
            gnt_b = req_b_i[k*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      div0_d    = div0_q;
      tmo_d     = tmo_q;
      cnt_d     = cnt_q;
      div_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (gnt_found) begin
               id_d  = gnt;
               a_d   = gnt_a;
               b_d   = gnt_b;
               ptr_d = rr_idx(gnt, 1);
               if (gnt_b == '0) begin
                  quo_d   = '1;
                  rem_d   = gnt_a;
                  div0_d  = 1'b1;
                  tmo_d   = 1'b0;
                  state_d = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (div_ready_i) begin
               div_start = 1'b1;
               cnt_d     = '0;
               state_d   = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + CW'(1);
            // The end pulse takes priority over a simultaneous watchdog expiry.
            if (div_end_i) begin
               quo_d   = div_quotient_i;
               rem_d   = div_remainder_i;
               div0_d  = 1'b0;
               tmo_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == CW'(TMO_CYC - 1)) begin
               quo_d   = '0;
               rem_d   = '0;
               div0_d  = 1'b0;
               tmo_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready_i[id_q]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         div0_q  <= 1'b0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         div0_q  <= div0_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      // Gated by rst_i so outputs read zero throughout reset.
      if (state_q == StIdle && gnt_found && !rst_i) begin
         req_ready_o[gnt] = 1'b1;
      end
      if (state_q == StResp) begin
         rsp_valid_o[id_q] = 1'b1;
      end
   end

   assign div_start_o     = div_start;
   assign div_a_o         = a_q;
   assign div_b_o         = b_q;
   assign rsp_quotient_o  = (state_q == StResp) ? quo_q : '0;
   assign rsp_remainder_o = (state_q == StResp) ? rem_q : '0;
   assign rsp_div0_o      = (state_q == StResp) && div0_q;
   assign rsp_tmo_o       = (state_q == StResp) && tmo_q;
   assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_div_share_sched.sv
// Bench for div_share_sched: vector table, corner-case sequences and a
// randomized phase checked against a round-robin reference model.
module tb_div_share_sched;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*DW-1:0] req_a, req_b;
   logic            div_start, div_ready, div_end, rsp_div0, rsp_tmo, busy;
   logic [DW-1:0]   div_a, div_b, div_quotient, div_remainder, rsp_quotient, rsp_remainder;

   int total = 0;
   int bad   = 0;

   // Divider model controls
   int            lat       = 3;
   bit            hang      = 1'b0;
   bit            stray_en  = 1'b0;
   bit            rand_lat  = 1'b0;
   int            start_cnt = 0;
   logic [DW-1:0] last_sa   = '0;
   logic [DW-1:0] last_sb   = '0;

   always #5 clk = ~clk;

   div_share_sched #(.N_REQ(N), .DW(DW), .TMO_CYC(TMO)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_a_i        (req_a),
      .req_b_i        (req_b),
      .div_start_o    (div_start),
      .div_a_o        (div_a),
      .div_b_o        (div_b),
      .div_ready_i    (div_ready),
      .div_end_i      (div_end),
      .div_quotient_i (div_quotient),
      .div_remainder_i(div_remainder),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_quotient_o (rsp_quotient),
      .rsp_remainder_o(rsp_remainder),
      .rsp_div0_o     (rsp_div0),
      .rsp_tmo_o      (rsp_tmo),
      .busy_o         (busy)
   );

   // Iterative divider: end pulse 'lat' cycles after start; garbage data otherwise.
   initial begin
      bit            st, dbusy;
      logic [DW-1:0] sa, sb, da, db;
      int            dcnt;
      div_ready = 1'b1; div_end = 1'b0; div_quotient = '0; div_remainder = '0;
      dbusy = 1'b0; dcnt = 0; da = '0; db = 1;
      forever begin
         @(negedge clk);
         st = div_start; sa = div_a; sb = div_b;
         @(posedge clk); #1;
         div_end = 1'b0; div_quotient = $urandom; div_remainder = $urandom;
         if (st) begin
            start_cnt++; last_sa = sa; last_sb = sb; da = sa; db = sb;
            dbusy = 1'b1; div_ready = 1'b0;
            dcnt = rand_lat ? int'($urandom_range(1, 6)) : lat;
         end
         if (dbusy) begin
            dcnt--;
            if (dcnt == 0) begin
               dbusy = 1'b0; div_ready = 1'b1;
               if (!hang) begin
                  div_end = 1'b1;
                  div_quotient  = (db != 0) ? da / db : '1;
                  div_remainder = (db != 0) ? da % db : da;
               end
            end
         end else if (stray_en && $urandom_range(0, 3) == 0) begin
            div_end = 1'b1;
         end
      end
   end

   function automatic logic [N-1:0] oh(input int k);
      logic [N-1:0] one;
      one = 1;
      return one << k;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string t);
      check({t, ".busy"}, busy, 0);
      check({t, ".rsp_valid"}, rsp_valid, 0);
      check({t, ".req_ready"}, req_ready, 0);
      check({t, ".div_start"}, div_start, 0);
      check({t, ".div_a"}, div_a, 0);
      check({t, ".div_b"}, div_b, 0);
      check({t, ".rsp_q"}, rsp_quotient, 0);
      check({t, ".rsp_r"}, rsp_remainder, 0);
      check({t, ".div0"}, rsp_div0, 0);
      check({t, ".tmo"}, rsp_tmo, 0);
   endtask

   task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_valid[id] = 1'b1;
      req_a[id*DW +: DW] = a;
      req_b[id*DW +: DW] = b;
   endtask

   task automatic accept(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input string t);
      @(posedge clk); #1;
      req_valid = '0;
      set_req(id, a, b);
      @(negedge clk);
      check({t, ".accept"}, req_ready, oh(id));
      check({t, ".idle"}, busy, 0);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(input int bound, input string t, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rsp_valid == '0 && n < bound);
      check({t, ".rsp_seen"}, rsp_valid != '0, 1);
   endtask

   task automatic ack(input int id, input string t);
      rsp_ready = oh(id);
      @(negedge clk);
      check({t, ".ack"}, rsp_valid, 0);
      rsp_ready = '0;
   endtask

   task automatic do_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] eq, input logic [DW-1:0] er, input bit ed0,
                        input string t);
      int n, s0;
      s0 = start_cnt;
      accept(id, a, b, t);
      wait_rsp(TMO + 10, t, n);
      check({t, ".latency"}, n, ed0 ? 1 : 2 + lat);
      check({t, ".valid"}, rsp_valid, oh(id));
      check({t, ".q"}, rsp_quotient, eq);
      check({t, ".r"}, rsp_remainder, er);
      check({t, ".div0"}, rsp_div0, ed0);
      check({t, ".tmo"}, rsp_tmo, 0);
      check({t, ".starts"}, start_cnt - s0, ed0 ? 0 : 1);
      if (!ed0) begin
         check({t, ".div_a"}, last_sa, a);
         check({t, ".div_b"}, last_sb, b);
      end
      // Ready from other requesters must not complete the response.
      rsp_ready = ~oh(id);
      @(negedge clk);
      check({t, ".hold"}, rsp_valid, oh(id));
      check({t, ".hold_q"}, rsp_quotient, eq);
      ack(id, t);
      check({t, ".done"}, busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      int            id;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      bit            d0;
   } vec_t;

   initial begin
      vec_t          tbl[9];
      logic [DW-1:0] rr_a[N];
      logic [DW-1:0] rr_b[N];
      int            n;
      bit            flag;
      int            m_ptr, e_id, bcnt, g;
      bit            m_busy, late_seen;
      logic [DW-1:0] e_q, e_r, ea, eb;
      bit            e_d0;

      tbl[0] = '{2, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
      tbl[1] = '{1, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1};
      tbl[2] = '{0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0};
      tbl[3] = '{3, 32'd999, 32'd3, 32'd333, 32'd0, 1'b0};
      tbl[4] = '{0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
      tbl[5] = '{3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
      tbl[6] = '{1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1};
      tbl[7] = '{2, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
      tbl[8] = '{0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};

      rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
      #2 check_zero("reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].d0,
               $sformatf("vec%0d", i));
      end

      // Watchdog: divider never pulses its end.
      hang = 1'b1;
      accept(2, 32'd50, 32'd5, "tmo");
      wait_rsp(TMO + 10, "tmo", n);
      check("tmo.latency", n, TMO + 2);
      check("tmo.valid", rsp_valid, oh(2));
      check("tmo.flag", rsp_tmo, 1);
      check("tmo.q", rsp_quotient, 0);
      check("tmo.r", rsp_remainder, 0);
      check("tmo.div0", rsp_div0, 0);
      ack(2, "tmo");
      hang = 1'b0;
      do_op(1, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, "after_tmo");

      // Response backpressure with stray end pulses in flight.
      stray_en = 1'b1;
      accept(0, 32'd300, 32'd7, "bp");
      set_req(3, 32'd40, 32'd6);
      wait_rsp(TMO + 10, "bp", n);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp.valid", rsp_valid, oh(0));
         check("bp.q", rsp_quotient, 32'd42);
         check("bp.r", rsp_remainder, 32'd6);
         check("bp.no_accept", req_ready, 0);
      end
      rsp_ready = oh(0);
      @(negedge clk);
      rsp_ready = '0;
      check("bp.released", rsp_valid, 0);
      check("bp.grant3", req_ready, oh(3));
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(TMO + 10, "bp3", n);
      check("bp3.valid", rsp_valid, oh(3));
      check("bp3.q", rsp_quotient, 32'd6);
      check("bp3.r", rsp_remainder, 32'd4);
      ack(3, "bp3");
      stray_en = 1'b0;

      // Round-robin order from pointer 0 with all requesters valid.
      do_reset();
      rr_a = '{32'd1000, 32'd999, 32'd77, 32'd65536};
      rr_b = '{32'd10, 32'd3, 32'd5, 32'd256};
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) set_req(k, rr_a[k], rr_b[k]);
      for (int j = 0; j < 5; j++) begin
         n = 0;
         if (j == 0) @(negedge clk);
         while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("rr%0d.grant", j), req_ready, oh(j % N));
         if (j == 4) begin
            @(posedge clk); #1;
            req_valid = '0;
         end
         wait_rsp(TMO + 10, "rr", n);
         check($sformatf("rr%0d.valid", j), rsp_valid, oh(j % N));
         check($sformatf("rr%0d.q", j), rsp_quotient, rr_a[j % N] / rr_b[j % N]);
         check($sformatf("rr%0d.r", j), rsp_remainder, rr_a[j % N] % rr_b[j % N]);
         ack(j % N, "rr");
      end

      // Reset while waiting on the divider; its late end pulse must be ignored.
      lat = 8;
      accept(0, 32'd77, 32'd7, "rstw");
      repeat (3) @(negedge clk);
      check("rstw.in_wait", busy, 1);
      rst = 1'b1;
      #1 check_zero("rstw");
      @(negedge clk);
      rst = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy || rsp_valid != '0) flag = 1'b1;
      end
      check("rstw.late_end_ignored", flag, 0);
      lat = 3;
      do_op(1, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, "post_rst");

      // Randomized traffic against the reference model.
      do_reset();
      rand_lat = 1'b1; stray_en = 1'b1;
      m_ptr = 0; m_busy = 1'b0; late_seen = 1'b0;
      e_id = 0; e_q = '0; e_r = '0; e_d0 = 1'b0; bcnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         for (int k = 0; k < N; k++) begin
            int sel;
            req_valid[k] = ($urandom_range(0, 2) == 0);
            req_a[k*DW +: DW] = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 200);
            sel = $urandom_range(0, 3);
            req_b[k*DW +: DW] = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 15) : $urandom;
         end
         rsp_ready = N'($urandom_range(0, 15));
         @(negedge clk);
         if (!m_busy) begin
            g = -1;
            for (int off = 0; off < N; off++) begin
               if (g < 0 && req_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
            end
            check("rand.ready", req_ready, (g < 0) ? '0 : oh(g));
            check("rand.idle_rsp", rsp_valid, 0);
            if (g >= 0) begin
               ea = req_a[g*DW +: DW];
               eb = req_b[g*DW +: DW];
               e_id = g; e_d0 = (eb == 0);
               e_q  = e_d0 ? '1 : ea / eb;
               e_r  = e_d0 ? ea : ea % eb;
               m_ptr = (g + 1) % N; m_busy = 1'b1; bcnt = 0;
            end
         end else begin
            bcnt++;
            check("rand.no_accept", req_ready, 0);
            if (rsp_valid != '0) begin
               check("rand.valid", rsp_valid, oh(e_id));
               check("rand.q", rsp_quotient, e_q);
               check("rand.r", rsp_remainder, e_r);
               check("rand.div0", rsp_div0, e_d0);
               check("rand.tmo", rsp_tmo, 0);
               if (rsp_ready[e_id]) m_busy = 1'b0;
            end else if (bcnt > TMO + 12 && !late_seen) begin
               late_seen = 1'b1;
               check("rand.rsp_late", bcnt, TMO + 12);
            end
         end
      end
      @(posedge clk); #1;
      req_valid = '0; rsp_ready = '1;
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Round-robin scheduler that shares one iterative divider among N_REQ requesters (ALU clients in the qnet IP).
- Accepts one division request at a time and starts the divider.
- Captures quotient and remainder on the divider's end pulse, then returns them to the originating requester over a valid/ready response channel.
- Handles divide-by-zero locally and guards the divider with a watchdog.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 32, operand and result width.
- TMO_CYC, 64, watchdog limit in cycles from div_start_o to div_end_i; must exceed divider latency.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  N_REQ*DW  dividends, requester k at bits [k*DW +: DW].
- req_b_i  in  N_REQ*DW  divisors, same packing.
- div_start_o  out  1  single-cycle start to divider.
- div_a_o  out  DW  dividend to divider.
- div_b_o  out  DW  divisor to divider.
- div_ready_i  in  1  divider idle.
- div_end_i  in  1  divider result-valid pulse.
- div_quotient_i  in  DW  divider quotient.
- div_remainder_i  in  DW  divider remainder.
- rsp_valid_o  out  N_REQ  per-requester response valid; one-hot or zero.
- rsp_ready_i  in  N_REQ  per-requester response accept.
- rsp_quotient_o  out  DW  result quotient, shared bus.
- rsp_remainder_o  out  DW  result remainder, shared bus.
- rsp_div0_o  out  1  response is a divide-by-zero result.
- rsp_tmo_o  out  1  response is a watchdog-aborted result.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; round-robin pointer=0; tmo counter=0; id, A and B registers=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first k with req_valid_i[k], searching from pointer upward and wrapping modulo N_REQ.
  - In the same cycle: req_ready_o[g]=1 (combinational from req_valid_i and state); latch id=g, A=req_a_i[g], B=req_b_i[g]; pointer <= (g+1) mod N_REQ.
  - If req_b_i[g]==0: latch quotient={DW{1'b1}}, remainder=A, div0=1, then go to RESP.
  - Otherwise go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE:
  - div_a_o/div_b_o are driven from the latched A/B in all states.
  - When div_ready_i=1: div_start_o=1 for exactly one cycle, tmo counter cleared, go to WAIT.
  - Otherwise wait with div_start_o=0.
- WAIT:
  - tmo counter increments each cycle.
  - If div_end_i=1: latch div_quotient_i/div_remainder_i in that cycle (divider outputs valid only with the end pulse); div0=0, tmo=0; go to RESP.
  - Else if counter reaches TMO_CYC-1: quotient=0, remainder=0, tmo=1; go to RESP.
  - If div_end_i and timeout occur in the same cycle, div_end_i wins.
- RESP:
  - rsp_valid_o[id]=1; rsp_quotient_o, rsp_remainder_o, rsp_div0_o and rsp_tmo_o are held stable.
  - On rsp_ready_i[id]=1: go to IDLE, deassert rsp_valid_o next cycle.
  - rsp_ready_i bits for other ids are ignored.
  - rsp_* data buses read 0 whenever rsp_valid_o==0.
- Throughput and latency:
  - One operation in flight.
  - Minimum request-accept to rsp_valid_o: 2 + L cycles (L = divider start-to-end latency); 1 cycle for the div0 path.
  - Next accept occurs at the earliest in the cycle after the response handshake.
- Fairness: a requester holding req_valid_i waits at most N_REQ-1 other grants.
- Stray div_end_i outside WAIT is ignored and must not corrupt latched results.
- Reset asserted mid-operation: immediate return to the reset state. Any divider operation in flight is abandoned; its later end pulse arrives in IDLE and is ignored.
- req_valid_i dropped before grant: no accept. No holding requirement on requesters before grant.

Test Plan:
- Single request, requester 2, A=100, B=7 -> one div_start_o with div_a_o=100, div_b_o=7; on the end pulse, rsp_valid_o=4'b0100, quotient=14, remainder=2, div0=0, tmo=0.
- Requesters 0..3 all valid continuously, pointer=0 -> grant order 0,1,2,3,0. Each response is returned to the matching id with correct quotients for distinct operands (e.g. 1000/10=100, 999/3=333).
- Requester 1, A=55, B=0 -> no div_start_o; rsp_valid_o[1] one cycle after accept; quotient=0xFFFFFFFF, remainder=55, div0=1.
- Divider model never pulses div_end_i -> after TMO_CYC cycles rsp_tmo_o=1, quotient=0, remainder=0. A following request is served normally.
- Response backpressure: rsp_ready_i[0] held low for 10 cycles -> rsp_valid_o and data stable; no further accepts; requester 3 is granted only after the handshake.
- rst_i asserted while in WAIT -> all outputs 0 asynchronously. The late div_end_i is ignored; the next request (A=9, B=4) returns quotient 2, remainder 1.
